// File: rtl/fle_frac_pkg.sv
// Shared bit-map positions and chain length for the fracturable logic element.
// Defining FLE_FRAC_CFG_PARITY_EN appends an even-parity bit to the chain.
package fle_frac_pkg;

  function automatic int unsigned lut_bits(input int unsigned k);
    return 32'd1 << k;
  endfunction

  function automatic int unsigned frac_idx(input int unsigned k);
    return lut_bits(k);
  endfunction

  function automatic int unsigned regsel0_idx(input int unsigned k);
    return lut_bits(k) + 1;
  endfunction

  function automatic int unsigned regsel1_idx(input int unsigned k);
    return lut_bits(k) + 2;
  endfunction

  function automatic int unsigned par_idx(input int unsigned k);
    return lut_bits(k) + 3;
  endfunction

  function automatic int unsigned cfg_len(input int unsigned k);
`ifdef FLE_FRAC_CFG_PARITY_EN
    return lut_bits(k) + 4;
`else
    return lut_bits(k) + 3;
`endif
  endfunction

endpackage

// File: rtl/fle_frac_lut.sv
// Combinational K-LUT, optionally fractured into two (K-1)-LUTs that share
// the low K-1 inputs and select the lower/upper halves of the mask.
module fle_frac_lut #(
  parameter int unsigned K = 6
) (
  input  logic [(1<<K)-1:0] mask,
  input  logic              frac,
  input  logic [K-1:0]      fle_in,
  output logic              lut_a,
  output logic              lut_b
);

  logic [K-1:0] idx_a;
  logic [K-1:0] idx_b;

  always_comb begin
    idx_a = fle_in;
    idx_b = fle_in;
    if (frac) begin
      idx_a = {1'b0, fle_in[K-2:0]};
      idx_b = {1'b1, fle_in[K-2:0]};
    end
    lut_a = mask[idx_a];
    lut_b = mask[idx_b];
  end

endmodule

// File: rtl/fle_frac_cfg.sv
// Fracturable logic element with a serial configuration chain and bit counter.
// FLE_FRAC_CFG_PARITY_EN adds a parity bit and the cfg_err check.
module fle_frac_cfg
  import fle_frac_pkg::*;
#(
  parameter int unsigned K = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         prog_en,
  input  logic         ccff_head,
  output logic         ccff_tail,
  input  logic [K-1:0] fle_in,
  input  logic         fle_ce,
  output logic [1:0]   fle_out,
  output logic         cfg_valid,
  output logic         cfg_err
);

  localparam int unsigned LUT_BITS    = lut_bits(K);
  localparam int unsigned FRAC_IDX    = frac_idx(K);
  localparam int unsigned REGSEL0_IDX = regsel0_idx(K);
  localparam int unsigned REGSEL1_IDX = regsel1_idx(K);
  localparam int unsigned CFG_LEN     = cfg_len(K);
  localparam int unsigned CNT_W       = $clog2(CFG_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CFG_LEN);

  logic [CFG_LEN-1:0] cfg_q, cfg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ff0_q, ff0_d;
  logic               ff1_q, ff1_d;
  logic               lut_a, lut_b;

  fle_frac_lut #(.K(K)) u_lut (
    .mask   (cfg_q[LUT_BITS-1:0]),
    .frac   (cfg_q[FRAC_IDX]),
    .fle_in (fle_in),
    .lut_a  (lut_a),
    .lut_b  (lut_b)
  );

  // Shifting takes priority over the user flops so they never capture a
  // LUT output built from a half-loaded mask.
  always_comb begin
    cfg_d = cfg_q;
    cnt_d = cnt_q;
    ff0_d = ff0_q;
    ff1_d = ff1_q;
    if (prog_en) begin
      cfg_d = {cfg_q[CFG_LEN-2:0], ccff_head};
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    end else if (fle_ce) begin
      ff0_d = lut_a;
      ff1_d = lut_b;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_q <= '0;
      cnt_q <= '0;
      ff0_q <= 1'b0;
      ff1_q <= 1'b0;
    end else begin
      cfg_q <= cfg_d;
      cnt_q <= cnt_d;
      ff0_q <= ff0_d;
      ff1_q <= ff1_d;
    end
  end

  assign ccff_tail = cfg_q[CFG_LEN-1];
  assign cfg_valid = (cnt_q == CNT_MAX) && !prog_en;

`ifdef FLE_FRAC_CFG_PARITY_EN
  assign cfg_err = cfg_valid && (^cfg_q);
`else
  assign cfg_err = 1'b0;
`endif

  always_comb begin
    fle_out = '0;
    if (cfg_valid && !cfg_err) begin
      fle_out[0] = cfg_q[REGSEL0_IDX] ? ff0_q : lut_a;
      fle_out[1] = cfg_q[REGSEL1_IDX] ? ff1_q : lut_b;
    end
  end

endmodule
